gen_reg_arbiter: RTL
====================

GEN_REG_ARBITER -- requirements
Module: gen_reg_arbiter

Interface
REQ-001 SHALL have parameter MAX_BURST, default 4, meaning the maximum consecutive grant cycles per locked burst (legal range 1..16).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port arb_en_i, input, 1 bit: when high, new arbitration rounds are allowed.
REQ-005 SHALL have port req_i, input, 8 bits: per-requester write request to the general register; bit k corresponds to source select k.
REQ-006 SHALL have port lock_i, input, 8 bits: per-requester burst request, sampled only for the requester currently granted.
REQ-007 SHALL have port SrcSel_o, output, 3 bits: registered source select for the general register.
REQ-008 SHALL have port en_o, output, 1 bit: registered load enable for the general register.
REQ-009 SHALL have port gnt_o, output, 8 bits: registered one-hot grant, equal to (en_o ? 1<<SrcSel_o : 0).
REQ-010 SHALL have port busy_o, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, GRANT and BURST.
REQ-012 In IDLE with arb_en_i=1 and req_i!=0, the block SHALL select a winner round-robin, searching from ptr upward with wrap 7->0, and SHALL enter GRANT.
REQ-013 On entering GRANT, the block SHALL register SrcSel_o=winner, en_o=1, gnt_o=one-hot(winner) and cnt=1, so the grant appears one cycle after req_i is sampled.
REQ-014 In IDLE with arb_en_i=0 or req_i=0, the block SHALL stay in IDLE with en_o=0 and gnt_o=0; SrcSel_o SHALL hold its last value.
REQ-015 In GRANT or BURST, if req_i[SrcSel_o] & lock_i[SrcSel_o] & (cnt<MAX_BURST), the block SHALL go to (or stay in) BURST, keep en_o=1 and SrcSel_o unchanged, and increment cnt.
REQ-016 In GRANT or BURST, if the REQ-015 condition is false, the block SHALL return to IDLE, clear en_o and gnt_o on the next edge, and set ptr=(SrcSel_o+1) mod 8.
REQ-017 Because of REQ-016, the block SHALL leave at least one idle cycle between separate grants, giving a maximum non-burst throughput of one grant per two cycles.
REQ-018 With MAX_BURST=1, the block SHALL ignore lock_i and never enter BURST.
REQ-019 The arbiter SHALL NOT sample lock_i of non-granted requesters and SHALL NOT sample req_i of non-granted requesters while in GRANT or BURST.
REQ-020 arb_en_i falling during GRANT or BURST SHALL NOT truncate the current burst; it SHALL only block the next IDLE arbitration.
REQ-021 If the granted requester drops req_i in GRANT or BURST, the block SHALL end the burst per REQ-016.
REQ-022 A req_i pulse that rises and falls entirely while the FSM is outside IDLE SHALL be lost, and SHALL NOT be recorded.
REQ-023 cnt SHALL be ceil(log2(MAX_BURST+1)) bits wide and SHALL never exceed MAX_BURST.
REQ-024 The block SHALL keep gnt_o one-hot or zero at all times.
REQ-025 All outputs SHALL be driven from flops, with no combinational path from inputs to outputs.

Reset
REQ-026 While rst=1, regardless of clock, the block SHALL force state=IDLE, ptr=0, cnt=0, SrcSel_o=0, en_o=0, gnt_o=0 and busy_o=0.
REQ-027 Reset asserted mid-burst SHALL abort the burst immediately, with en_o low without waiting for a clock edge.
REQ-028 After rst falls, the first arbitration SHALL start at the first rising edge and SHALL use ptr=0.

Verification
REQ-029 The bench SHALL cover single request: after reset, req_i=8'h08 held -> next cycle SrcSel_o=3, en_o=1, gnt_o=8'h08; the cycle after, en_o=0 and ptr=4.
REQ-030 The bench SHALL cover round-robin: req_i=8'h81 held continuously, lock_i=0 -> grants alternate 0,7,0,7, each one cycle wide with one idle cycle between them.
REQ-031 The bench SHALL cover burst cap: MAX_BURST=4, req_i=lock_i=8'h04 held -> en_o high exactly 4 consecutive cycles with SrcSel_o=2, then low for 1 cycle, then regranted.
REQ-032 The bench SHALL cover early burst exit: lock burst on requester 5, req_i[5] dropped in the 2nd grant cycle -> en_o low on the following edge and ptr=6.
REQ-033 The bench SHALL cover the enable gate: arb_en_i=0 with req_i=8'hFF -> no grant; arb_en_i raised -> grant to ptr; arb_en_i dropped mid-burst -> burst completes.
REQ-034 The bench SHALL cover async reset: rst pulsed between clock edges during a BURST -> en_o, gnt_o and busy_o go to 0 immediately, and the next grant after reset starts from requester 0.

Source files
------------

// File: rtl/gen_reg_arbiter_if.sv
// rtl/gen_reg_arbiter_if.sv - request/grant bundle between requesters and the general-register arbiter
// master = requester side, slave = arbiter side.
interface gen_reg_arbiter_if;
  logic       arb_en_i;
  logic [7:0] req_i;
  logic [7:0] lock_i;
  logic [2:0] SrcSel_o;
  logic       en_o;
  logic [7:0] gnt_o;
  logic       busy_o;

  modport master (
    output arb_en_i, req_i, lock_i,
    input  SrcSel_o, en_o, gnt_o, busy_o
  );

  modport slave (
    input  arb_en_i, req_i, lock_i,
    output SrcSel_o, en_o, gnt_o, busy_o
  );
endinterface

// File: rtl/gen_reg_arbiter.sv
// rtl/gen_reg_arbiter.sv - round-robin arbiter driving the general register source select with locked bursts
// Single-FSM design; every output is a flop, so nothing combinational reaches the interface outputs.
module gen_reg_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  gen_reg_arbiter_if.slave       bus
);

  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BURST = 2'd2
  } state_t;

  state_t          state;
  logic [2:0]      ptr;
  logic [CW-1:0]   cnt;
  logic [2:0]      src_sel;
  logic            en;
  logic [7:0]      gnt;
  logic            busy;

  // First set bit at or above start, wrapping 7->0; the downward scan lets the
  // smallest offset overwrite the result last.
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] start);
    logic [2:0] idx;
    rr_pick = start;
    for (int i = 7; i >= 0; i--) begin
      idx = start + 3'(i);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

  logic [2:0] winner;
  logic       keep;

  always_comb begin
    winner = rr_pick(bus.req_i, ptr);
    // Only the granted requester's req/lock bits are ever looked at here.
    keep   = bus.req_i[src_sel] & bus.lock_i[src_sel] & (cnt < CW'(MAX_BURST));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= 3'd0;
      cnt     <= '0;
      src_sel <= 3'd0;
      en      <= 1'b0;
      gnt     <= 8'h00;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.arb_en_i && (bus.req_i != 8'h00)) begin
            state   <= GRANT;
            src_sel <= winner;
            en      <= 1'b1;
            gnt     <= 8'h01 << winner;
            cnt     <= CW'(1);
            busy    <= 1'b1;
          end else begin
            en   <= 1'b0;
            gnt  <= 8'h00;
            busy <= 1'b0;
          end
        end
        GRANT, BURST: begin
          if (keep) begin
            state <= BURST;
            cnt   <= cnt + CW'(1);
            en    <= 1'b1;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            cnt   <= '0;
            en    <= 1'b0;
            gnt   <= 8'h00;
            busy  <= 1'b0;
            ptr   <= src_sel + 3'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          en    <= 1'b0;
          gnt   <= 8'h00;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.SrcSel_o = src_sel;
  assign bus.en_o     = en;
  assign bus.gnt_o    = gnt;
  assign bus.busy_o   = busy;

endmodule
